hazard_fwd_unit: RTL

- Parametrised hazard and forwarding controller for the pipelined processor.
- Generalises the fixed 2-port, 2-bit ForwardA/ForwardB and Stall control to N register read ports and a configurable number of tracked post-decode stages.
- Keeps its own registered table of in-flight destinations (EX..WB), so the datapath only supplies decode-stage fields plus branch resolution.
- Drives operand forward selects, IF/ID stall, and ID/EX flushes.

---
 rtl/hazard_fwd_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard detection and operand forwarding for the pipeline.
// Tracks destinations in flight (EX..WB) in its own table and produces
// per-read-port forward selects, the load-use stall, and the IF/ID and
// ID/EX flushes.
// Optional build macro HAZ_PERF_EN adds saturating 16-bit counters for
// stall cycles, branch flush cycles and forwarding cycles.
module hazard_fwd_unit #(
  parameter int AW       = 3,
  parameter int NRP      = 2,
  parameter int NSTG     = 3,
  parameter int LOAD_STG = 1,
  parameter int R0_ZERO  = 1,
  localparam int FSW     = $clog2(NSTG+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NRP-1:0]       id_rd_en,
  input  logic [NRP*AW-1:0]    id_ra,
  input  logic                 id_we,
  input  logic [AW-1:0]        id_wa,
  input  logic                 id_load,
  input  logic                 br_taken,
  output logic [NRP*FSW-1:0]   fwd_sel,
  output logic                 stall,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [NSTG-1:0]      stg_valid
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0]          perf_stall,
  output logic [15:0]          perf_flush,
  output logic [15:0]          perf_fwd
`endif
);

  // In-flight table; index 0 is EX, NSTG-1 is WB.
  logic [NSTG-1:0]         ent_v, ent_we, ent_ld;
  logic [NSTG-1:0][AW-1:0] ent_wa;
  logic [NRP-1:0]          haz;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0]   ra;
    logic [NSTG-1:0] hit;
    logic [FSW-1:0]  sel;
    logic            lu;

    assign ra = id_ra[p*AW +: AW];

    // Per-stage match of this port's source against tracked destinations.
    always_comb begin
      hit = '0;
      for (int k = 0; k < NSTG; k++)
        hit[k] = id_rd_en[p] & ent_v[k] & ent_we[k] & (ent_wa[k] == ra) &
                 !((R0_ZERO != 0) && (ra == '0));
    end

    // Scan oldest to youngest so the youngest match overwrites the rest;
    // a too-young load blocks any older match and flags load-use.
    always_comb begin
      sel = '0;
      lu  = 1'b0;
      for (int k = NSTG-1; k >= 0; k--) begin
        if (hit[k]) begin
          if (ent_ld[k] && (k < LOAD_STG)) begin
            lu  = 1'b1;
            sel = '0;
          end else begin
            lu  = 1'b0;
            sel = FSW'(k+1);
          end
        end
      end
    end

    assign fwd_sel[p*FSW +: FSW] = sel;
    assign haz[p]                = lu;
  end

  // A taken branch squashes the decode instruction, so its hazard is moot.
  assign stall     = id_valid & (|haz) & ~br_taken;
  assign flush_e   = stall | br_taken;
  assign flush_d   = br_taken;
  assign stg_valid = ent_v;

  // Table always advances; EX gets a bubble on stall or taken branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_v  <= '0;
      ent_we <= '0;
      ent_ld <= '0;
      ent_wa <= '0;
    end else begin
      for (int k = NSTG-1; k >= 1; k--) begin
        ent_v[k]  <= ent_v[k-1];
        ent_we[k] <= ent_we[k-1];
        ent_ld[k] <= ent_ld[k-1];
        ent_wa[k] <= ent_wa[k-1];
      end
      if (br_taken || stall) begin
        ent_v[0]  <= 1'b0;
        ent_we[0] <= 1'b0;
        ent_ld[0] <= 1'b0;
        ent_wa[0] <= '0;
      end else begin
        ent_v[0]  <= id_valid;
        ent_we[0] <= id_we;
        ent_ld[0] <= id_load;
        ent_wa[0] <= id_wa;
      end
    end
  end

`ifdef HAZ_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_fwd   <= '0;
    end else begin
      if (stall && perf_stall != 16'hFFFF)              perf_stall <= perf_stall + 16'd1;
      if (br_taken && perf_flush != 16'hFFFF)           perf_flush <= perf_flush + 16'd1;
      if ((|fwd_sel) && perf_fwd != 16'hFFFF)           perf_fwd   <= perf_fwd + 16'd1;
    end
  end
`endif

endmodule
